// File: rtl/addsub_pkg.sv
// Shared types for the add/subtract stream unit: FSM states and operation select.
package addsub_pkg;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_t;

    // Reference-width result record; the top re-declares the same layout at
    // its own WIDTH because a package type cannot follow a module parameter.
    localparam int REF_WIDTH = 16;

    typedef struct packed {
        logic                 ovf;
        logic [REF_WIDTH-1:0] data;
    } result_t;

endpackage

// File: rtl/result_fifo.sv
// Result queue: W bits x DEPTH entries, synchronous clear, occupancy counter
// distinguishes full from empty. Head data reads as zero when empty.
module result_fifo
    import addsub_pkg::*;
#(
    parameter int W     = 17,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop,
    output logic [W-1:0]               pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Next pointers and occupancy; clear takes priority over both transfers.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are only meaningful below the occupancy count.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem_q[wr_ptr_q] <= push_data;
    end

    assign pop_data = empty ? '0 : mem_q[rd_ptr_q];
    assign count    = count_q;

endmodule

// File: rtl/addsub_stream_unit.sv
// Streaming signed add/subtract with wrap or saturate arithmetic and a result
// FIFO. Handshake: a transfer happens on a rising edge where valid && ready;
// ready never depends on valid of the same channel nor on out_ready.
module addsub_stream_unit
    import addsub_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 4,
    parameter int SATURATE = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_a,
    input  logic [WIDTH-1:0]           in_b,
    input  logic                       in_op,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_ovf,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [1:0]                 state
);

    typedef struct packed {
        logic             ovf;
        logic [WIDTH-1:0] data;
    } res_t;

    state_t       state_q, state_d;
    logic [WIDTH:0] a_ext, b_ext, sum;
    res_t         res_in, res_out;
    logic         fifo_clear, fifo_full, fifo_empty, push, pop;

    // Sign-extended arithmetic; the extra bit exposes signed overflow.
    always_comb begin
        a_ext       = {in_a[WIDTH-1], in_a};
        b_ext       = {in_b[WIDTH-1], in_b};
        sum         = (op_t'(in_op) == OP_SUB) ? (a_ext - b_ext) : (a_ext + b_ext);
        res_in.ovf  = sum[WIDTH] ^ sum[WIDTH-1];
        res_in.data = sum[WIDTH-1:0];
        if (res_in.ovf && (SATURATE != 0)) begin
            res_in.data = sum[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}}
                                     : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end

    // Next state and handshake; a clear in RUN flushes on the same edge.
    always_comb begin
        state_d    = state_q;
        in_ready   = 1'b0;
        fifo_clear = 1'b0;
        case (state_q)
            INIT: state_d = RUN;
            RUN: begin
                in_ready = !fifo_full;
                if (clear) begin
                    state_d    = FLUSH;
                    fifo_clear = 1'b1;
                end
            end
            FLUSH: begin
                fifo_clear = 1'b1;
                state_d    = RUN;
            end
            default: state_d = INIT;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= INIT;
        else     state_q <= state_d;
    end

    assign out_valid = !fifo_empty && (state_q != FLUSH);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    result_fifo #(
        .W     (WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (fifo_clear),
        .push      (push),
        .push_data (res_in),
        .pop       (pop),
        .pop_data  (res_out),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (count)
    );

    assign out_data = res_out.data;
    assign out_ovf  = res_out.ovf;
    assign state    = state_q;

endmodule

// File: tb/tb_addsub_stream_unit.sv
// Directed bench for addsub_stream_unit at WIDTH=8, DEPTH=4; a wrap instance
// and a saturate instance see identical stimulus.
module tb_addsub_stream_unit;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int CW = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         clear = 1'b0, in_valid = 1'b0, in_op = 1'b0, out_ready = 1'b0;
    logic [W-1:0] in_a = '0, in_b = '0;

    logic          in_ready_w, out_valid_w, out_ovf_w;
    logic [W-1:0]  out_data_w;
    logic [CW-1:0] count_w;
    logic [1:0]    state_w;
    logic          in_ready_s, out_valid_s, out_ovf_s;
    logic [W-1:0]  out_data_s;
    logic [CW-1:0] count_s;
    logic [1:0]    state_s;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [W:0] exp_w_q[$];
    logic [W:0] exp_s_q[$];

    addsub_stream_unit #(.WIDTH(W), .DEPTH(D), .SATURATE(0)) dut_w (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready_w),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid_w),
        .out_ready(out_ready), .out_data(out_data_w), .out_ovf(out_ovf_w),
        .count(count_w), .state(state_w)
    );

    addsub_stream_unit #(.WIDTH(W), .DEPTH(D), .SATURATE(1)) dut_s (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid_s),
        .out_ready(out_ready), .out_data(out_data_s), .out_ovf(out_ovf_s),
        .count(count_s), .state(state_s)
    );

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_status(input string tag, input int cnt, input logic rdy,
                                input logic vld);
        check({tag, "_count_w"}, 32'(count_w), 32'(cnt));
        check({tag, "_count_s"}, 32'(count_s), 32'(cnt));
        check({tag, "_in_ready_w"}, 32'(in_ready_w), 32'(rdy));
        check({tag, "_in_ready_s"}, 32'(in_ready_s), 32'(rdy));
        check({tag, "_out_valid_w"}, 32'(out_valid_w), 32'(vld));
        check({tag, "_out_valid_s"}, 32'(out_valid_s), 32'(vld));
    endtask

    task automatic check_state(input string tag, input logic [1:0] st);
        check({tag, "_state_w"}, 32'(state_w), 32'(st));
        check({tag, "_state_s"}, 32'(state_s), 32'(st));
    endtask

    // Compare both heads against the scoreboard fronts (or zero when empty).
    task automatic check_head(input string tag);
        logic [W:0] ew, es;
        ew = '0;
        es = '0;
        if (exp_w_q.size() > 0) ew = exp_w_q[0];
        if (exp_s_q.size() > 0) es = exp_s_q[0];
        check({tag, "_head_w"}, 32'({out_ovf_w, out_data_w}), 32'(ew));
        check({tag, "_head_s"}, 32'({out_ovf_s, out_data_s}), 32'(es));
    endtask

    task automatic pop_exp();
        if (exp_w_q.size() > 0) void'(exp_w_q.pop_front());
        if (exp_s_q.size() > 0) void'(exp_s_q.pop_front());
    endtask

    task automatic exp_push(input logic [W:0] w, input logic [W:0] s);
        exp_w_q.push_back(w);
        exp_s_q.push_back(s);
    endtask

    // Small reference for the random streaming phase.
    task automatic model_push(input int a, input int b, input logic op);
        int         t;
        logic       ov;
        logic [W:0] w, s;
        t  = op ? (a - b) : (a + b);
        ov = (t > 127) || (t < -128);
        w  = {ov, t[7:0]};
        s  = w;
        if (ov) s = {1'b1, (t > 0) ? 8'h7f : 8'h80};
        exp_push(w, s);
    endtask

    // ---------------- driver ----------------
    task automatic drive(input int a, input int b, input logic op);
        in_a     = a[W-1:0];
        in_b     = b[W-1:0];
        in_op    = op;
        in_valid = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int a, b;
        logic op;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check_status("reset", 0, 1'b0, 1'b0);
        check_state("reset", 2'd0);
        check_head("reset");
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_state("init", 2'd0);
        check("init_in_ready_w", 32'(in_ready_w), 32'd0);
        tick();
        check_state("run", 2'd1);
        check("run_in_ready_w", 32'(in_ready_w), 32'd1);

        // 5 + 3 = 8, visible right after the transfer edge
        drive(5, 3, 1'b0);
        exp_push(9'h008, 9'h008);
        tick();
        in_valid = 1'b0;
        check_status("add", 1, 1'b1, 1'b1);
        check_head("add");
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        pop_exp();
        check_status("add_pop", 0, 1'b1, 1'b0);
        check_head("add_pop");

        // Overflow vectors fill the FIFO (hand-computed wrap / saturate)
        drive(100, 100, 1'b0);  exp_push(9'h1C8, 9'h17F); tick();
        drive(-128, 1, 1'b1);   exp_push(9'h17F, 9'h180); tick();
        drive(-100, -100, 1'b0); exp_push(9'h138, 9'h180); tick();
        drive(127, -1, 1'b1);   exp_push(9'h180, 9'h17F); tick();
        check_status("full", 4, 1'b0, 1'b1);
        drive(1, 1, 1'b0);
        tick();
        check_status("full_hold", 4, 1'b0, 1'b1);
        check_head("full_hold");
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_head($sformatf("drain%0d", i));
            tick();
            pop_exp();
            if (i == 0) check_status("first_pop", 3, 1'b1, 1'b1);
        end
        out_ready = 1'b0;
        check_status("drained", 0, 1'b1, 1'b0);

        // Streaming: push and pop every cycle for 20 operations
        out_ready = 1'b1;
        a  = int'($urandom_range(0, 255)) - 128;
        b  = int'($urandom_range(0, 255)) - 128;
        op = 1'($urandom_range(0, 1));
        drive(a, b, op);
        model_push(a, b, op);
        tick();
        for (int k = 1; k < 20; k++) begin
            check_status($sformatf("stream%0d", k), 1, 1'b1, 1'b1);
            check_head($sformatf("stream%0d", k));
            pop_exp();
            a  = int'($urandom_range(0, 255)) - 128;
            b  = int'($urandom_range(0, 255)) - 128;
            op = 1'($urandom_range(0, 1));
            drive(a, b, op);
            model_push(a, b, op);
            tick();
        end
        in_valid = 1'b0;
        check_head("stream_last");
        pop_exp();
        tick();
        check_status("stream_end", 0, 1'b1, 1'b0);
        out_ready = 1'b0;

        // Clear with count=3 and a concurrent push
        drive(1, 2, 1'b0); tick();
        drive(3, 4, 1'b0); tick();
        drive(5, 6, 1'b0); tick();
        check_status("pre_clear", 3, 1'b1, 1'b1);
        clear = 1'b1;
        drive(7, 8, 1'b0);
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        exp_w_q.delete();
        exp_s_q.delete();
        check_state("flush", 2'd2);
        check_status("flush", 0, 1'b0, 1'b0);
        tick();
        check_state("after_flush", 2'd1);
        check_status("after_flush", 0, 1'b1, 1'b0);

        // Asynchronous reset between edges with count=2
        drive(1, 1, 1'b0); tick();
        drive(2, 2, 1'b0); tick();
        in_valid = 1'b0;
        check_status("pre_rst", 2, 1'b1, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_status("async_rst", 0, 1'b0, 1'b0);
        check_state("async_rst", 2'd0);
        check_head("async_rst");
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_state("rst_init", 2'd0);
        check("rst_init_in_ready_s", 32'(in_ready_s), 32'd0);
        tick();
        check_state("rst_run", 2'd1);
        check_status("rst_run", 0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Watchdog against a stuck run
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
